// File: rtl/dop_mode_ctrl.sv
// rtl/dop_mode_ctrl.sv - DoP marker checker and PCM/ACQ/DSD/MUTE mode controller
// Routes each I2S frame to the PCM path, the DSD payload path, or drops it while muted.
module dop_mode_ctrl #(
   parameter int DW          = 16,
   parameter int LOCK_CNT    = 32,
   parameter int UNLOCK_CNT  = 4,
   parameter int MUTE_FRAMES = 64
) (
   input  logic          bclk,
   input  logic          rst,
   input  logic          valid_i,
   input  logic [DW+7:0] ldata_i,
   input  logic [DW+7:0] rdata_i,
   output logic          pcm_valid_o,
   output logic [DW+7:0] pcm_ldata_o,
   output logic [DW+7:0] pcm_rdata_o,
   output logic          dsd_valid_o,
   output logic [DW-1:0] dsd_ldata_o,
   output logic [DW-1:0] dsd_rdata_o,
   output logic          mode_o,
   output logic          mute_o,
   output logic          lock_err_o
);

   localparam int AW = $clog2(LOCK_CNT + 1);
   localparam int MW = $clog2(UNLOCK_CNT + 1);
   localparam int TW = $clog2(MUTE_FRAMES + 1);
   localparam logic [7:0]    MK_A    = 8'h05;
   localparam logic [7:0]    MK_B    = 8'hFA;
   localparam logic [DW-1:0] SILENCE = {(DW / 8){8'h69}};

   typedef enum logic [1:0] {S_PCM, S_ACQ, S_DSD, S_MUTE} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] acq_cnt, acq_nxt;
   logic [MW-1:0] miss_cnt, miss_nxt;
   logic [TW-1:0] mute_cnt, mute_nxt;
   logic          last_mk_vld;
   logic [7:0]    last_mk;
   logic [7:0]    lmk, rmk;
   logic          mk_is_dop, good;
   logic          pcm_fire, dsd_fire, dsd_sil, lerr_fire;

   assign lmk       = ldata_i[DW+7:DW];
   assign rmk       = rdata_i[DW+7:DW];
   assign mk_is_dop = (lmk == MK_A) || (lmk == MK_B);
   // A repeat of the previous marker means the alternation broke; "none" never matches.
   assign good      = (lmk == rmk) && mk_is_dop && !(last_mk_vld && (lmk == last_mk));

   assign mode_o = (state == S_DSD);
   assign mute_o = (state == S_ACQ) || (state == S_MUTE);

   always_comb begin
      state_nxt = state;
      acq_nxt   = acq_cnt;
      miss_nxt  = miss_cnt;
      mute_nxt  = mute_cnt;
      pcm_fire  = 1'b0;
      dsd_fire  = 1'b0;
      dsd_sil   = 1'b0;
      lerr_fire = 1'b0;
      if (valid_i) begin
         case (state)
            S_PCM: begin
               if (good) begin
                  state_nxt = S_ACQ;
                  acq_nxt   = AW'(1);
               end else begin
                  pcm_fire = 1'b1;
               end
            end
            S_ACQ: begin
               if (good) begin
                  if (acq_cnt >= AW'(LOCK_CNT - 1)) begin
                     state_nxt = S_DSD;
                     acq_nxt   = '0;
                     miss_nxt  = '0;
                     dsd_fire  = 1'b1;
                  end else begin
                     acq_nxt = acq_cnt + AW'(1);
                  end
               end else begin
                  state_nxt = S_PCM;
                  acq_nxt   = '0;
                  pcm_fire  = 1'b1;
               end
            end
            S_DSD: begin
               if (good) begin
                  miss_nxt = '0;
                  dsd_fire = 1'b1;
               end else if (miss_cnt >= MW'(UNLOCK_CNT - 1)) begin
                  state_nxt = S_MUTE;
                  miss_nxt  = MW'(UNLOCK_CNT);
                  mute_nxt  = '0;
                  lerr_fire = 1'b1;
               end else begin
                  miss_nxt = miss_cnt + MW'(1);
                  dsd_fire = 1'b1;
                  dsd_sil  = 1'b1;
               end
            end
            S_MUTE: begin
               if (mute_cnt >= TW'(MUTE_FRAMES - 1)) begin
                  state_nxt = S_PCM;
                  mute_nxt  = '0;
               end else begin
                  mute_nxt = mute_cnt + TW'(1);
               end
            end
            default: state_nxt = S_PCM;
         endcase
      end
   end

   always_ff @(posedge bclk or negedge rst) begin
      if (!rst) begin
         state       <= S_PCM;
         acq_cnt     <= '0;
         miss_cnt    <= '0;
         mute_cnt    <= '0;
         last_mk_vld <= 1'b0;
         last_mk     <= '0;
         pcm_valid_o <= 1'b0;
         pcm_ldata_o <= '0;
         pcm_rdata_o <= '0;
         dsd_valid_o <= 1'b0;
         dsd_ldata_o <= '0;
         dsd_rdata_o <= '0;
         lock_err_o  <= 1'b0;
      end else begin
         state       <= state_nxt;
         acq_cnt     <= acq_nxt;
         miss_cnt    <= miss_nxt;
         mute_cnt    <= mute_nxt;
         pcm_valid_o <= pcm_fire;
         dsd_valid_o <= dsd_fire;
         lock_err_o  <= lerr_fire;
         // Track any valid DoP marker, good or bad, so a single glitch cannot cascade.
         if (valid_i && mk_is_dop) begin
            last_mk_vld <= 1'b1;
            last_mk     <= lmk;
         end
         if (pcm_fire) begin
            pcm_ldata_o <= ldata_i;
            pcm_rdata_o <= rdata_i;
         end
         if (dsd_fire) begin
            dsd_ldata_o <= dsd_sil ? SILENCE : ldata_i[DW-1:0];
            dsd_rdata_o <= dsd_sil ? SILENCE : rdata_i[DW-1:0];
         end
      end
   end

endmodule

// File: tb/tb_dop_mode_ctrl.sv
// tb/tb_dop_mode_ctrl.sv - scoreboard testbench for dop_mode_ctrl
module tb_dop_mode_ctrl;

   localparam int DW    = 16;
   localparam int K_NON = 0;
   localparam int K_PCM = 1;
   localparam int K_DSD = 2;
   localparam int K_LER = 3;
   localparam int K_SIL = 4;

   logic          bclk = 1'b0;
   logic          rst  = 1'b0;
   logic          valid_i = 1'b0;
   logic [DW+7:0] ldata_i = '0;
   logic [DW+7:0] rdata_i = '0;
   logic          pcm_valid_o, dsd_valid_o, mode_o, mute_o, lock_err_o;
   logic [DW+7:0] pcm_ldata_o, pcm_rdata_o;
   logic [DW-1:0] dsd_ldata_o, dsd_rdata_o;

   typedef struct {
      int          kind;
      logic [23:0] l;
      logic [23:0] r;
      logic        mode;
      logic        mute;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   dop_mode_ctrl #(.DW(DW), .LOCK_CNT(32), .UNLOCK_CNT(4), .MUTE_FRAMES(64)) dut (
      .bclk(bclk), .rst(rst), .valid_i(valid_i), .ldata_i(ldata_i), .rdata_i(rdata_i),
      .pcm_valid_o(pcm_valid_o), .pcm_ldata_o(pcm_ldata_o), .pcm_rdata_o(pcm_rdata_o),
      .dsd_valid_o(dsd_valid_o), .dsd_ldata_o(dsd_ldata_o), .dsd_rdata_o(dsd_rdata_o),
      .mode_o(mode_o), .mute_o(mute_o), .lock_err_o(lock_err_o)
   );

   always #5 bclk = ~bclk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at posedge+1; presents one frame for one cycle and logs the expected response.
   task automatic send(input logic [7:0] lm, input logic [7:0] rm,
                       input logic [15:0] lp, input logic [15:0] rp, input int kind);
      exp_t e;
      valid_i = 1'b1;
      ldata_i = {lm, lp};
      rdata_i = {rm, rp};
      e.kind = kind;
      e.mode = 1'b0;
      e.mute = 1'b0;
      e.l    = {lm, lp};
      e.r    = {rm, rp};
      if (kind == K_DSD) begin
         e.mode = 1'b1;
         e.l    = {8'h00, lp};
         e.r    = {8'h00, rp};
      end else if (kind == K_SIL) begin
         e.kind = K_DSD;
         e.mode = 1'b1;
         e.l    = 24'h006969;
         e.r    = 24'h006969;
      end else if (kind == K_LER) begin
         e.mute = 1'b1;
      end
      if (kind != K_NON) q.push_back(e);
      @(posedge bclk);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge bclk);
         #1;
      end
   endtask

   always @(negedge bclk) begin
      if (rst && (pcm_valid_o || dsd_valid_o || lock_err_o)) begin
         int   ak;
         exp_t e;
         ak = 9;
         if (pcm_valid_o && !dsd_valid_o && !lock_err_o) ak = K_PCM;
         if (dsd_valid_o && !pcm_valid_o && !lock_err_o) ak = K_DSD;
         if (lock_err_o && !pcm_valid_o && !dsd_valid_o) ak = K_LER;
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got kind %0d expected none", ak);
         end else begin
            e = q.pop_front();
            chk("event_kind", 32'(ak), 32'(e.kind));
            if (e.kind == K_PCM) begin
               chk("pcm_ldata", {8'h00, pcm_ldata_o}, {8'h00, e.l});
               chk("pcm_rdata", {8'h00, pcm_rdata_o}, {8'h00, e.r});
            end else if (e.kind == K_DSD) begin
               chk("dsd_ldata", {16'h0, dsd_ldata_o}, {8'h00, e.l});
               chk("dsd_rdata", {16'h0, dsd_rdata_o}, {8'h00, e.r});
            end
            chk("event_mode", {31'h0, mode_o}, {31'h0, e.mode});
            chk("event_mute", {31'h0, mute_o}, {31'h0, e.mute});
         end
      end
   end

   initial begin
      logic [7:0] mk;
      // Reset state
      idle(3);
      chk("rst_mode", {31'h0, mode_o}, 32'h0);
      chk("rst_mute", {31'h0, mute_o}, 32'h0);
      chk("rst_valids", {29'h0, pcm_valid_o, dsd_valid_o, lock_err_o}, 32'h0);
      chk("rst_pcm_data", {8'h0, pcm_ldata_o}, 32'h0);
      rst = 1'b1;
      idle(2);

      // 1: PCM frames with a non-DoP marker pass unmodified
      for (int i = 0; i < 10; i++)
         send(8'h12, 8'h12, 16'(i * 16'h1111 + 1), 16'(16'hF000 - i), K_PCM);
      idle(2);

      // 2: lock onto 32 alternating DoP frames; 1..31 dropped, 32 on the DSD path
      for (int i = 0; i < 31; i++) begin
         mk = (i % 2 == 0) ? 8'h05 : 8'hFA;
         send(mk, mk, 16'hA5A5, 16'h3C3C, K_NON);
      end
      idle(1);
      chk("acq_mute", {31'h0, mute_o}, 32'h1);
      chk("acq_mode", {31'h0, mode_o}, 32'h0);
      send(8'hFA, 8'hFA, 16'hA5A5, 16'h3C3C, K_DSD);
      idle(2);

      // 3: one mismatched-marker frame gives silence; next good frame (FA) recovers
      send(8'h05, 8'hFA, 16'h1111, 16'h2222, K_SIL);
      send(8'hFA, 8'hFA, 16'h1234, 16'h5678, K_DSD);
      idle(2);
      chk("dsd_stays_mode", {31'h0, mode_o}, 32'h1);

      // 4: four bad frames back to back -> 3 silence, then lock error and mute
      send(8'h00, 8'h00, 16'h0101, 16'h0202, K_SIL);
      send(8'h00, 8'h00, 16'h0303, 16'h0404, K_SIL);
      send(8'h00, 8'h00, 16'h0505, 16'h0606, K_SIL);
      send(8'h00, 8'h00, 16'h0707, 16'h0808, K_LER);
      for (int i = 0; i < 63; i++) send(8'h12, 8'h12, 16'(i), 16'(i), K_NON);
      idle(1);
      chk("mute_held", {31'h0, mute_o}, 32'h1);
      send(8'h12, 8'h12, 16'hBEEF, 16'hBEEF, K_NON);
      idle(1);
      chk("unmute_mode", {31'h0, mode_o}, 32'h0);
      chk("unmute_mute", {31'h0, mute_o}, 32'h0);
      send(8'h12, 8'h12, 16'hCAFE, 16'hF00D, K_PCM);
      idle(2);

      // 5: ACQ broken by a repeated marker; last_mk is FA here, so start with 05
      for (int i = 0; i < 10; i++) begin
         mk = (i % 2 == 0) ? 8'h05 : 8'hFA;
         send(mk, mk, 16'h7777, 16'h8888, K_NON);
      end
      send(8'h05, 8'h05, 16'h9999, 16'hAAAA, K_NON);
      send(8'h05, 8'h05, 16'hBBBB, 16'hCCCC, K_PCM);
      idle(1);
      chk("acq_break_mute", {31'h0, mute_o}, 32'h0);
      idle(1);

      // 6: relock (last_mk is 05), then reset between pulses
      for (int i = 0; i < 31; i++) begin
         mk = (i % 2 == 0) ? 8'hFA : 8'h05;
         send(mk, mk, 16'h4242, 16'h2424, K_NON);
      end
      send(8'h05, 8'h05, 16'h4242, 16'h2424, K_DSD);
      idle(2);
      chk("relock_mode", {31'h0, mode_o}, 32'h1);
      rst = 1'b0;
      #1;
      chk("arst_dsd_ldata", {16'h0, dsd_ldata_o}, 32'h0);
      chk("arst_dsd_rdata", {16'h0, dsd_rdata_o}, 32'h0);
      chk("arst_pcm_ldata", {8'h0, pcm_ldata_o}, 32'h0);
      chk("arst_mode_mute", {30'h0, mode_o, mute_o}, 32'h0);
      idle(2);
      rst = 1'b1;
      idle(1);
      chk("post_rst_mode", {31'h0, mode_o}, 32'h0);
      // last_mk was cleared, so 05 is good again and enters ACQ
      send(8'h05, 8'h05, 16'h0F0F, 16'hF0F0, K_NON);
      idle(1);
      chk("post_rst_acq_mute", {31'h0, mute_o}, 32'h1);
      idle(4);

      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
